// File: rtl/parking_gate_ctrl.sv
// Entry-gate sequencer and 4-spot allocator: keeps the occupancy register,
// assigns the lowest free spot, runs the gate through open/pass/close with a timeout.
module parking_gate_ctrl #(
    parameter int unsigned GATE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       car_passed,
    input  logic       exit_valid,
    input  logic [1:0] exit_spot,
    output logic       gate_open,
    output logic [2:0] assigned_spot,
    output logic [3:0] occupancy,
    output logic [2:0] free_count,
    output logic       full,
    output logic       denied,
    output logic       exit_err,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] timer;
    logic [1:0] alloc_idx;
    logic       exit_hit;
    logic       pass_set;
    logic [3:0] occ_nxt;

    assign full   = &occupancy;
    assign denied = (state == IDLE) && entry_req && full;

    always_comb begin
        free_count = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            free_count = free_count + {2'b00, ~occupancy[i]};
        end
    end

    // Scan from the top so the lowest free index wins.
    always_comb begin
        alloc_idx = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!occupancy[i-1]) begin
                alloc_idx = 2'(i - 1);
            end
        end
    end

    // Exit clear and pass set share one update; an exit of the spot being
    // assigned sees a 0 bit, so it is rejected and the pass still sets it.
    always_comb begin
        exit_hit = exit_valid && occupancy[exit_spot];
        pass_set = (state == OPEN) && car_passed;
        occ_nxt  = occupancy;
        if (exit_hit) begin
            occ_nxt[exit_spot] = 1'b0;
        end
        if (pass_set) begin
            occ_nxt[assigned_spot[1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            gate_open     <= 1'b0;
            assigned_spot <= '1;
            occupancy     <= '0;
            exit_err      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            occupancy <= occ_nxt;
            exit_err  <= exit_valid && !occupancy[exit_spot];
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (entry_req && !full) begin
                        state         <= OPEN;
                        assigned_spot <= {1'b0, alloc_idx};
                        timer         <= '0;
                        gate_open     <= 1'b1;
                    end
                end
                OPEN: begin
                    if (car_passed) begin
                        gate_open <= 1'b0;
                        state     <= CLOSE;
                    end else if (timer == 8'(GATE_TIMEOUT - 1)) begin
                        gate_open <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= CLOSE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                CLOSE: begin
                    if (!entry_req) begin
                        assigned_spot <= '1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with hand-computed expectations.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       car_passed;
    logic       exit_valid;
    logic [1:0] exit_spot;
    logic       gate_open;
    logic [2:0] assigned_spot;
    logic [3:0] occupancy;
    logic [2:0] free_count;
    logic       full;
    logic       denied;
    logic       exit_err;
    logic       timeout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    parking_gate_ctrl #(.GATE_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entry_req     (entry_req),
        .car_passed    (car_passed),
        .exit_valid    (exit_valid),
        .exit_spot     (exit_spot),
        .gate_open     (gate_open),
        .assigned_spot (assigned_spot),
        .occupancy     (occupancy),
        .free_count    (free_count),
        .full          (full),
        .denied        (denied),
        .exit_err      (exit_err),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full 3-cycle entry: request, pass on the next edge, then release.
    task automatic do_entry(input logic [2:0] exp_spot, input logic [3:0] exp_occ);
        entry_req = 1'b1;
        step();
        check("entry_gate", 32'(gate_open), 1);
        check("entry_spot", 32'(assigned_spot), 32'(exp_spot));
        car_passed = 1'b1;
        step();
        car_passed = 1'b0;
        entry_req  = 1'b0;
        check("entry_occ", 32'(occupancy), 32'(exp_occ));
        check("entry_gate_closed", 32'(gate_open), 0);
        step();
        check("entry_release", 32'(assigned_spot), 7);
    endtask

    initial begin
        rst_n      = 1'b0;
        entry_req  = 1'b0;
        car_passed = 1'b0;
        exit_valid = 1'b0;
        exit_spot  = 2'd0;
        #13;
        check("rst_gate", 32'(gate_open), 0);
        check("rst_spot", 32'(assigned_spot), 7);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_free", 32'(free_count), 4);
        check("rst_full", 32'(full), 0);
        check("rst_denied", 32'(denied), 0);
        check("rst_exit_err", 32'(exit_err), 0);
        check("rst_timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        step();

        // Single entry, pass sampled three edges after the request.
        entry_req = 1'b1;
        step();
        check("t1_gate0", 32'(gate_open), 1);
        check("t1_spot", 32'(assigned_spot), 0);
        step();
        check("t1_gate1", 32'(gate_open), 1);
        step();
        check("t1_gate2", 32'(gate_open), 1);
        car_passed = 1'b1;
        step();
        car_passed = 1'b0;
        check("t1_gate_drop", 32'(gate_open), 0);
        check("t1_occ", 32'(occupancy), 4'b0001);
        check("t1_free", 32'(free_count), 3);
        check("t1_hold_spot", 32'(assigned_spot), 0);
        step();
        check("t1_wait_close", 32'(assigned_spot), 0);
        entry_req = 1'b0;
        step();
        check("t1_idle_spot", 32'(assigned_spot), 7);

        // Invalid exit of an empty spot.
        exit_valid = 1'b1;
        exit_spot  = 2'd1;
        step();
        exit_valid = 1'b0;
        check("bad_exit_err", 32'(exit_err), 1);
        check("bad_exit_occ", 32'(occupancy), 4'b0001);
        step();
        check("bad_exit_pulse", 32'(exit_err), 0);

        // Pass for spot 1 together with exit of spot 0.
        entry_req = 1'b1;
        step();
        check("same_spot", 32'(assigned_spot), 1);
        car_passed = 1'b1;
        exit_valid = 1'b1;
        exit_spot  = 2'd0;
        step();
        car_passed = 1'b0;
        exit_valid = 1'b0;
        entry_req  = 1'b0;
        check("same_occ", 32'(occupancy), 4'b0010);
        check("same_err", 32'(exit_err), 0);
        step();

        // Exit naming the spot being assigned: rejected, pass still sets it.
        entry_req = 1'b1;
        step();
        check("clash_spot", 32'(assigned_spot), 0);
        car_passed = 1'b1;
        exit_valid = 1'b1;
        exit_spot  = 2'd0;
        step();
        car_passed = 1'b0;
        exit_valid = 1'b0;
        entry_req  = 1'b0;
        check("clash_occ", 32'(occupancy), 4'b0011);
        check("clash_err", 32'(exit_err), 1);
        step();

        // Fill the lot.
        do_entry(3'd2, 4'b0111);
        do_entry(3'd3, 4'b1111);
        check("full_flag", 32'(full), 1);
        check("full_free", 32'(free_count), 0);
        entry_req = 1'b1;
        #1;
        check("deny_comb", 32'(denied), 1);
        step();
        check("deny_gate", 32'(gate_open), 0);
        check("deny_hold", 32'(denied), 1);

        // Exit of spot 2 while the request is held: allocation on the next edge.
        exit_valid = 1'b1;
        exit_spot  = 2'd2;
        step();
        exit_valid = 1'b0;
        check("reuse_occ", 32'(occupancy), 4'b1011);
        check("reuse_denied", 32'(denied), 0);
        check("reuse_gate_wait", 32'(gate_open), 0);
        step();
        check("reuse_gate", 32'(gate_open), 1);
        check("reuse_spot", 32'(assigned_spot), 2);
        car_passed = 1'b1;
        step();
        car_passed = 1'b0;
        entry_req  = 1'b0;
        check("reuse_refill", 32'(occupancy), 4'b1111);
        step();

        // Timeout with spot 3 free.
        exit_valid = 1'b1;
        exit_spot  = 2'd3;
        step();
        exit_valid = 1'b0;
        check("to_pre_occ", 32'(occupancy), 4'b0111);
        entry_req = 1'b1;
        step();
        check("to_spot", 32'(assigned_spot), 3);
        for (int i = 1; i < 16; i++) begin
            step();
            check("to_gate_held", 32'(gate_open), 1);
            check("to_no_pulse", 32'(timeout), 0);
        end
        step();
        check("to_gate_drop", 32'(gate_open), 0);
        check("to_pulse", 32'(timeout), 1);
        check("to_occ", 32'(occupancy), 4'b0111);
        step();
        check("to_pulse_end", 32'(timeout), 0);
        entry_req = 1'b0;
        step();
        check("to_idle", 32'(assigned_spot), 7);

        // Reset while the gate is open.
        entry_req = 1'b1;
        step();
        check("mid_gate", 32'(gate_open), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gate", 32'(gate_open), 0);
        check("mid_rst_spot", 32'(assigned_spot), 7);
        check("mid_rst_occ", 32'(occupancy), 0);
        check("mid_rst_free", 32'(free_count), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Entry-gate controller and spot allocator for the 4-spot parking system. It keeps the occupancy register and assigns each arriving car the lowest-numbered free spot. It also sequences the entry gate through open, pass and close, with a timeout, and clears spots on exit events. It sits between the entry/exit sensors and the gate actuator and display logic.

## Interface
- GATE_TIMEOUT, 16: maximum number of cycles the gate stays open waiting for car_passed; legal range 2..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- entry_req  in  1  car present at the entry sensor (level).
- car_passed  in  1  gate-pass sensor pulse; meaningful only while the gate is open.
- exit_valid  in  1  one-cycle exit event.
- exit_spot  in  2  spot index being vacated; qualified by exit_valid.
- gate_open  out  1  gate actuator command (registered).
- assigned_spot  out  3  {1'b0, idx} for the allocated spot; 3'b111 = none (registered).
- occupancy  out  4  bit i = spot i occupied (registered).
- free_count  out  3  number of zero bits in occupancy, 0..4 (combinational from the register).
- full  out  1  &occupancy (combinational from the register).
- denied  out  1  entry refused because the lot is full (combinational).
- exit_err  out  1  one-cycle pulse: exit_valid named an unoccupied spot (registered).
- timeout  out  1  one-cycle pulse: gate closed without a pass (registered).

## Operation
- FSM states: IDLE, OPEN, CLOSE.
- **IDLE:**
  - entry_req=1 and full=0 -> OPEN.
  - On that transition: assigned_spot <= lowest-index zero bit of occupancy; timer <= 0; gate_open <= 1.
  - entry_req=1 and full=1 -> stay in IDLE; denied=1 for as long as this holds.
- **OPEN:**
  - timer increments every cycle.
  - car_passed=1 -> occupancy[assigned_spot[1:0]] <= 1, gate_open <= 0, go to CLOSE.
  - Otherwise, when timer==GATE_TIMEOUT-1 -> gate_open <= 0, timeout pulse, go to CLOSE; occupancy is unchanged.
  - car_passed takes priority over timeout on the same edge.
- **CLOSE:**
  - assigned_spot is held.
  - When entry_req=0 -> IDLE, assigned_spot <= 3'b111.
  - Waiting here prevents one car from consuming two spots.
- **Exit handling** is independent of FSM state and evaluated every cycle:
  - exit_valid=1 and occupancy[exit_spot]=1 -> that bit is cleared.
  - exit_valid=1 and the bit is 0 -> no change, exit_err pulse.
- **Same-edge events:**
  - An exit clear and a car_passed set on different bits both apply.
  - An exit naming the spot currently being assigned sees that bit still 0, so exit_err fires, the exit is ignored, and car_passed still sets the bit.
- **Decision point:** the IDLE decision uses pre-edge occupancy. If an exit frees a spot on the same edge at which a full lot was denied, allocation happens on the next edge provided entry_req is still high.
- **Allocation:** is a fixed priority encoder, spot 0 highest priority. The allocated spot is never changed while in OPEN.

## Timing
- **Reset values (asynchronous, take effect immediately):**
  - state IDLE, gate_open 0, assigned_spot 3'b111, occupancy 4'b0000, timer 0, exit_err 0, timeout 0.
  - Derived outputs: free_count 3'd4, full 0, denied 0.
- **Reset mid-operation:** the gate drops within the reset assertion, not at a clock edge, and occupancy is lost.
- **Entry latency:** entry_req sampled high in IDLE at edge N -> gate_open and assigned_spot valid after edge N (one cycle).
- **Gate-open duration:**
  - With no pass, gate_open is high for exactly GATE_TIMEOUT cycles; the timeout pulse is coincident with gate_open falling.
  - car_passed sampled at edge M -> gate_open low and occupancy updated after edge M.
- **Exit latency:** exit_valid at edge K -> occupancy, free_count and full reflect the exit after edge K; exit_err is high for the single cycle after edge K.
- **Handshake:** back-to-back entries need at least one cycle with entry_req=0 between them; the minimum entry-to-entry spacing is 3 cycles.

## Test plan
- **Reset then single entry:** reset, then entry_req=1, then car_passed 3 cycles later -> assigned_spot=3'b000, gate_open high for 3 cycles, occupancy=0001, free_count=3.
- **Fill the lot:** four entries each followed by car_passed -> spots 0,1,2,3 assigned in order, full=1, free_count=0. A fifth entry_req -> denied=1, gate_open stays 0.
- **Timeout (GATE_TIMEOUT=16):** entry with no car_passed -> gate_open high for exactly 16 cycles, timeout pulse, occupancy unchanged.
- **Reuse of a freed spot:** with occupancy=1111, exit_spot=2 while entry_req is held high -> occupancy=1011, denied drops, and the next edge assigns 3'b010.
- **Invalid exit and same-edge events:**
  - exit_spot=1 with occupancy=0001 -> exit_err pulse, occupancy unchanged.
  - car_passed for spot 1 together with exit of spot 0 -> occupancy=0010.
- **Reset mid-OPEN:** rst_n low while gate_open=1 -> gate_open=0 and assigned_spot=3'b111 immediately, occupancy=0000.
